serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to add the presented operands; sampled only in IDLE.
REQ-005 SHALL have port operand_a  input  WIDTH  addend, captured when start is accepted.
REQ-006 SHALL have port operand_b  input  WIDTH  augend, captured when start is accepted.
REQ-007 SHALL have port carry_in  input  1  initial carry, captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high in RUN and DONE states.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result and carry_out are valid in that cycle.
REQ-010 SHALL have port result  output  WIDTH  sum of the accepted operands, modulo 2^WIDTH.
REQ-011 SHALL have port carry_out  output  1  carry out of the MSB.
REQ-012 SHALL have port overflow  output  1  signed two's-complement overflow; present only when SERIAL_ADDER_OVF_EN is defined.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL move IDLE->RUN on an edge with start=1; on that edge it SHALL load operand shift registers, set carry register to carry_in, and clear bit counter and result.
REQ-015 SHALL, on each RUN edge, add LSBs of both shift registers plus carry register through one full-adder cell, shift the sum bit into result MSB (result shifts right), shift both operand registers right, and store the cell carry.
REQ-016 SHALL stay in RUN for exactly WIDTH edges, then go RUN->DONE; counter wrap from WIDTH-1 SHALL trigger the transition.
REQ-017 SHALL assert done for exactly the one cycle spent in DONE, then go DONE->IDLE unconditionally.
REQ-018 SHALL produce the following latency: start accepted at edge k gives done=1 in the cycle after edge k+WIDTH (WIDTH+1 cycles after the accept).
REQ-019 SHALL hold result, carry_out (and overflow) stable from DONE until the next accepted start.
REQ-020 SHALL ignore start in RUN and DONE, with no effect on state or data; start held high continuously SHALL yield back-to-back operations separated by one IDLE cycle.
REQ-021 SHALL drive carry_out equal to the carry register after the final RUN edge; WIDTH-bit arithmetic only, with no internal widening visible at ports.

Reset
REQ-022 SHALL, while sys_rst=1 at an edge, enter IDLE and clear busy, done, result, carry_out, overflow, counter, carry and shift registers to 0.
REQ-023 SHALL let reset override everything else; reset during RUN or DONE SHALL abort the operation with no done pulse.
REQ-024 SHALL honour the first start only on an edge after sys_rst is deasserted.

Configuration
REQ-025 SHALL provide macro SERIAL_ADDER_OVF_EN: when defined, overflow = carry into MSB XOR carry out of MSB, registered on the last RUN edge and held like result; when undefined, the overflow port and its logic are absent.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default WIDTH constant in shared package serial_adder_pkg.
REQ-027 SHALL instantiate the team's existing full_adder module exactly once as the bit-slice sub-module (ports addend, augend, carry_in, sum, carry_out); no other arithmetic operator SHALL compute the sum.
REQ-028 SHALL use a counter width of clog2(WIDTH).

Verification
REQ-029 SHALL cover: WIDTH=8, a=8'h0F, b=8'h01, cin=0 -> result=8'h10, carry_out=0, done exactly 9 cycles after accept edge.
REQ-030 SHALL cover: a=8'hFF, b=8'h01, cin=0 -> result=8'h00, carry_out=1; with macro, overflow=0.
REQ-031 SHALL cover: with macro, a=8'h7F, b=8'h01, cin=0 -> result=8'h80, overflow=1, carry_out=0; a=8'hFF, b=8'hFF, cin=1 -> result=8'hFF, carry_out=1.
REQ-032 SHALL cover: second start pulsed during RUN with different operands -> ignored; first result reported, single done pulse.
REQ-033 SHALL cover: sys_rst asserted on 4th RUN cycle -> next cycle busy=0, result=0, no done; fresh start afterwards completes correctly.
REQ-034 SHALL cover: 1000 random operand/cin sets with start held high -> each result/carry_out equals {carry_out,result} = a+b+cin; done spacing WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding and default width.
package serial_adder_pkg;

   localparam int unsigned SA_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sa_state_e;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// One-bit full-adder cell; the serial adder pushes every sum bit through this slice.
module full_adder (
   input  logic addend,
   input  logic augend,
   input  logic carry_in,
   output logic sum,
   output logic carry_out
);

   logic half_sum;

   assign half_sum  = addend ^ augend;
   assign sum       = half_sum ^ carry_in;
   assign carry_out = (addend & augend) | (carry_in & half_sum);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH RUN cycles per operation.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             start,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             overflow
`endif
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   sa_state_e        state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fa_sum;
   logic             fa_cout;
   logic             last_bit;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   full_adder u_full_adder (
      .addend    (a_q[0]),
      .augend    (b_q[0]),
      .carry_in  (carry_q),
      .sum       (fa_sum),
      .carry_out (fa_cout)
   );

   assign last_bit = (cnt_q == CNT_LAST);

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = operand_a;
               b_d     = operand_b;
               carry_d = carry_in;
               cnt_d   = '0;
               res_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = 1'b0;
`endif
            end
         end
         ST_RUN: begin
            // Sum bits enter at the MSB so the finished word lines up after WIDTH shifts.
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            res_d   = {fa_sum, res_q[WIDTH-1:1]};
            carry_d = fa_cout;
            if (last_bit) begin
               cnt_d   = '0;
               state_d = ST_DONE;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = carry_q ^ fa_cout;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      // NOTE: synchronous reset lives inside the clocked block and clears all state; <= only here.
      if (sys_rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign done      = (state_q == ST_DONE);
   assign result    = res_q;
   assign carry_out = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign overflow  = ovf_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed and held-start random checks for serial_adder (WIDTH=8); inputs driven and
// outputs sampled on the falling clock edge.
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic         sys_clk;
   logic         sys_rst;
   logic         start;
   logic [W-1:0] operand_a;
   logic [W-1:0] operand_b;
   logic         carry_in;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
`ifdef SERIAL_ADDER_OVF_EN
   logic         overflow;
`endif

   int checks   = 0;
   int failures = 0;

   serial_adder #(.WIDTH(W)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .start     (start),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .carry_in  (carry_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .overflow  (overflow)
`endif
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one operation at the current falling edge and returns at the falling edge
   // where done is seen; lat is the number of falling edges waited (-1 on timeout).
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output int lat);
      operand_a = a;
      operand_b = b;
      carry_in  = cin;
      start     = 1'b1;
      lat       = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge sys_clk);
         start = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      int            lat;
      int            dones;
      logic [W-1:0]  res_at_done;
      logic [W:0]    exp_sum;
      logic [W-1:0]  ra, rb;
      logic          rc;

      sys_rst   = 1'b1;
      start     = 1'b1;
      operand_a = 8'h5A;
      operand_b = 8'hA5;
      carry_in  = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("rst_busy",  32'(busy),      32'h0);
      check("rst_done",  32'(done),      32'h0);
      check("rst_result", 32'(result),   32'h0);
      check("rst_cout",  32'(carry_out), 32'h0);
`ifdef SERIAL_ADDER_OVF_EN
      check("rst_ovf",   32'(overflow),  32'h0);
`endif
      start   = 1'b0;
      sys_rst = 1'b0;
      @(negedge sys_clk);
      check("idle_after_rst_busy", 32'(busy), 32'h0);

      // 0F + 01 + 0
      do_op(8'h0F, 8'h01, 1'b0, lat);
      check("op1_latency", 32'(lat),       32'd9);
      check("op1_result",  32'(result),    32'h10);
      check("op1_cout",    32'(carry_out), 32'h0);
      check("op1_busy",    32'(busy),      32'h1);
      @(negedge sys_clk);
      check("op1_done_one_cycle", 32'(done), 32'h0);
      check("op1_idle_busy",      32'(busy), 32'h0);
      repeat (3) @(negedge sys_clk);
      check("op1_hold_result", 32'(result),    32'h10);
      check("op1_hold_done",   32'(done),      32'h0);

      // FF + 01 + 0
      do_op(8'hFF, 8'h01, 1'b0, lat);
      check("op2_latency", 32'(lat),       32'd9);
      check("op2_result",  32'(result),    32'h00);
      check("op2_cout",    32'(carry_out), 32'h1);
`ifdef SERIAL_ADDER_OVF_EN
      check("op2_ovf",     32'(overflow),  32'h0);
`endif
      @(negedge sys_clk);

      // 7F + 01 + 0
      do_op(8'h7F, 8'h01, 1'b0, lat);
      check("op3_result", 32'(result),    32'h80);
      check("op3_cout",   32'(carry_out), 32'h0);
`ifdef SERIAL_ADDER_OVF_EN
      check("op3_ovf",    32'(overflow),  32'h1);
`endif
      repeat (2) @(negedge sys_clk);
      check("op3_hold_result", 32'(result), 32'h80);

      // FF + FF + 1
      do_op(8'hFF, 8'hFF, 1'b1, lat);
      check("op4_result", 32'(result),    32'hFF);
      check("op4_cout",   32'(carry_out), 32'h1);
`ifdef SERIAL_ADDER_OVF_EN
      check("op4_ovf",    32'(overflow),  32'h0);
`endif
      @(negedge sys_clk);

      // 12 + 34 with a second start (AA + 55 + 1) pulsed on the third RUN cycle
      operand_a   = 8'h12;
      operand_b   = 8'h34;
      carry_in    = 1'b0;
      start       = 1'b1;
      dones       = 0;
      lat         = -1;
      res_at_done = '0;
      for (int n = 1; n <= 25; n++) begin
         @(negedge sys_clk);
         start = 1'b0;
         if (n == 3) begin
            start     = 1'b1;
            operand_a = 8'hAA;
            operand_b = 8'h55;
            carry_in  = 1'b1;
         end
         if (done) begin
            dones++;
            if (lat < 0) begin
               lat         = n;
               res_at_done = result;
            end
         end
      end
      check("ign_done_count", 32'(dones),       32'd1);
      check("ign_latency",    32'(lat),         32'd9);
      check("ign_result",     32'(res_at_done), 32'h46);
      check("ign_hold",       32'(result),      32'h46);

      // reset on the fourth RUN cycle of 33 + 11
      operand_a = 8'h33;
      operand_b = 8'h11;
      carry_in  = 1'b1;
      start     = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         @(negedge sys_clk);
         start = 1'b0;
      end
      check("abort_busy_before", 32'(busy), 32'h1);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      check("abort_busy",   32'(busy),      32'h0);
      check("abort_result", 32'(result),    32'h0);
      check("abort_cout",   32'(carry_out), 32'h0);
      check("abort_done",   32'(done),      32'h0);
      dones = 0;
      for (int n = 0; n < 15; n++) begin
         @(negedge sys_clk);
         if (done) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);
      do_op(8'h33, 8'h11, 1'b1, lat);
      check("fresh_latency", 32'(lat),       32'd9);
      check("fresh_result",  32'(result),    32'h45);
      check("fresh_cout",    32'(carry_out), 32'h0);
      @(negedge sys_clk);

      // 1000 random operations with start held high: done every W+2 cycles
      ra        = 8'($urandom);
      rb        = 8'($urandom);
      rc        = 1'($urandom);
      operand_a = ra;
      operand_b = rb;
      carry_in  = rc;
      start     = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         lat = -1;
         for (int n = 1; n <= 40; n++) begin
            @(negedge sys_clk);
            if (done) begin
               lat = n;
               break;
            end
         end
         exp_sum = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
         check("rnd_spacing", 32'(lat),       (k == 0) ? 32'd9 : 32'd10);
         check("rnd_result",  32'(result),    32'(exp_sum[W-1:0]));
         check("rnd_cout",    32'(carry_out), 32'(exp_sum[W]));
         if (lat < 0) break;
         ra        = 8'($urandom);
         rb        = 8'($urandom);
         rc        = 1'($urandom);
         operand_a = ra;
         operand_b = rb;
         carry_in  = rc;
         if (k == 999) start = 1'b0;
      end
      repeat (3) @(negedge sys_clk);
      check("end_idle_busy", 32'(busy), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_adder
